// File: rtl/result_frame_receiver.sv
// result_frame_receiver
//   Host-side deserializer for the minimizer's result stream. Recovers 8N1 UART bytes from the
//   serial line, parses result frames (header, count, 10-bit results) and presents each result
//   on a valid/ready port together with a per-frame summary.
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   t              serial input, idle high
//   res_data       current result word
//   res_idx        index of res_data within its frame (0-based)
//   res_valid      res_data/res_idx valid; held until res_ready
//   res_ready      consumer accepts the result when high with res_valid
//   frame_cap      capacity field of the last header
//   frame_err_code error field of the last header (0 = no error)
//   frame_count    result count of the last frame
//   frame_done     1-cycle pulse: frame fully parsed
//   proto_err      1-cycle pulse: framing/format/timeout error, frame discarded
//   overrun        sticky: a result was dropped because res_valid was still pending
module result_frame_receiver #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned MAX_RESULTS  = 16,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       t,
    output logic [9:0] res_data,
    output logic [5:0] res_idx,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [2:0] frame_cap,
    output logic [2:0] frame_err_code,
    output logic [5:0] frame_count,
    output logic       frame_done,
    output logic       proto_err,
    output logic       overrun
);

    localparam int unsigned BaudW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned ToLimit = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned ToW     = $clog2(ToLimit + 1);

    localparam logic [BaudW-1:0] BitLast  = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BaudW-1:0] HalfLast = BaudW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ToW-1:0]   ToMax    = ToW'(ToLimit);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {FrHunt, FrCnt, FrLo, FrHi} fr_state_e;

    // ------------------------------------------------------------------
    // Line synchronizer and byte receiver
    // ------------------------------------------------------------------
    logic [1:0]       sync_q;
    logic             line_prev_q;
    logic             line;
    rx_state_e        rx_state_q, rx_state_d;
    logic [BaudW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_strobe;
    logic             stop_err;

    assign line = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            line_prev_q <= 1'b1;
            rx_state_q  <= RxIdle;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
        end else begin
            sync_q      <= {sync_q[0], t};
            line_prev_q <= line;
            rx_state_q  <= rx_state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_strobe = 1'b0;
        stop_err    = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (line_prev_q && !line) rx_state_d = RxStart;
            end
            RxStart: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (baud_cnt_q == HalfLast) begin
                    baud_cnt_d = '0;
                    rx_state_d = line ? RxIdle : RxData;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (baud_cnt_q == BitLast) begin
                    baud_cnt_d = '0;
                    shift_d    = {line, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) rx_state_d = RxStop;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (baud_cnt_q == BitLast) begin
                    baud_cnt_d  = '0;
                    rx_state_d  = RxIdle;
                    byte_strobe = line;
                    stop_err    = !line;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame parser and result port
    // ------------------------------------------------------------------
    fr_state_e      fr_state_q, fr_state_d;
    logic [5:0]     n_q, n_d;
    logic [5:0]     idx_q, idx_d;
    logic [7:0]     lo_q, lo_d;
    logic [9:0]     res_data_q, res_data_d;
    logic [5:0]     res_idx_q, res_idx_d;
    logic           res_valid_q, res_valid_d;
    logic [2:0]     cap_q, cap_d;
    logic [2:0]     err_q, err_d;
    logic [5:0]     count_q, count_d;
    logic           done_q, done_d;
    logic           perr_q, perr_d;
    logic           overrun_q, overrun_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic [5:0]     idx_inc;

    assign idx_inc = idx_q + 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fr_state_q  <= FrHunt;
            n_q         <= '0;
            idx_q       <= '0;
            lo_q        <= '0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_valid_q <= 1'b0;
            cap_q       <= '0;
            err_q       <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            overrun_q   <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            fr_state_q  <= fr_state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            lo_q        <= lo_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            res_valid_q <= res_valid_d;
            cap_q       <= cap_d;
            err_q       <= err_d;
            count_q     <= count_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
            overrun_q   <= overrun_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    always_comb begin
        fr_state_d  = fr_state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        res_valid_d = res_valid_q && !res_ready;
        cap_d       = cap_q;
        err_d       = err_q;
        count_d     = count_q;
        done_d      = 1'b0;
        perr_d      = 1'b0;
        overrun_d   = overrun_q;
        to_cnt_d    = to_cnt_q;

        // Inter-byte timer runs only inside a frame and saturates at the limit.
        if (fr_state_q != FrHunt && to_cnt_q != ToMax) to_cnt_d = to_cnt_q + 1'b1;

        if (stop_err) begin
            perr_d     = 1'b1;
            fr_state_d = FrHunt;
        end else if (byte_strobe) begin
            to_cnt_d = '0;
            unique case (fr_state_q)
                FrHunt: begin
                    // Anything that is not a header is line noise; drop it quietly.
                    if (shift_q[7:6] == 2'b10) begin
                        cap_d = shift_q[2:0];
                        err_d = shift_q[5:3];
                        if (shift_q[5:3] != 3'd0) begin
                            count_d = '0;
                            done_d  = 1'b1;
                        end else begin
                            fr_state_d = FrCnt;
                        end
                    end
                end
                FrCnt: begin
                    if (shift_q[7:6] != 2'b00 || 32'(shift_q[5:0]) > MAX_RESULTS) begin
                        perr_d     = 1'b1;
                        fr_state_d = FrHunt;
                    end else if (shift_q[5:0] == 6'd0) begin
                        count_d    = '0;
                        done_d     = 1'b1;
                        fr_state_d = FrHunt;
                    end else begin
                        count_d    = shift_q[5:0];
                        err_d      = '0;
                        n_d        = shift_q[5:0];
                        idx_d      = '0;
                        fr_state_d = FrLo;
                    end
                end
                FrLo: begin
                    lo_d       = shift_q;
                    fr_state_d = FrHi;
                end
                FrHi: begin
                    if (shift_q[7:2] != 6'd0) begin
                        perr_d     = 1'b1;
                        fr_state_d = FrHunt;
                    end else begin
                        // A word accepted this cycle frees the slot for the new one.
                        if (!res_valid_q || res_ready) begin
                            res_data_d  = {shift_q[1:0], lo_q};
                            res_idx_d   = idx_q;
                            res_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                        idx_d = idx_inc;
                        if (idx_inc == n_q) begin
                            done_d     = 1'b1;
                            fr_state_d = FrHunt;
                        end else begin
                            fr_state_d = FrLo;
                        end
                    end
                end
                default: fr_state_d = FrHunt;
            endcase
        end else if (fr_state_q != FrHunt && to_cnt_q == ToMax && rx_state_q == RxIdle) begin
            perr_d     = 1'b1;
            fr_state_d = FrHunt;
        end
    end

    assign res_data       = res_data_q;
    assign res_idx        = res_idx_q;
    assign res_valid      = res_valid_q;
    assign frame_cap      = cap_q;
    assign frame_err_code = err_q;
    assign frame_count    = count_q;
    assign frame_done     = done_q;
    assign proto_err      = perr_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_result_frame_receiver.sv
// Directed bench for result_frame_receiver with CLKS_PER_BIT=16.
module tb_result_frame_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       t = 1'b1;
    logic [9:0] res_data;
    logic [5:0] res_idx;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [2:0] frame_cap;
    logic [2:0] frame_err_code;
    logic [5:0] frame_count;
    logic       frame_done;
    logic       proto_err;
    logic       overrun;

    int nchk = 0;
    int nfail = 0;

    int         done_cnt = 0;
    int         perr_cnt = 0;
    logic       done_rv = 1'b0;
    logic [9:0] done_rd = '0;
    logic [9:0] got_data[$];
    logic [5:0] got_idx[$];

    result_frame_receiver #(
        .CLKS_PER_BIT(CPB),
        .MAX_RESULTS (16),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .t             (t),
        .res_data      (res_data),
        .res_idx       (res_idx),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .frame_cap     (frame_cap),
        .frame_err_code(frame_err_code),
        .frame_count   (frame_count),
        .frame_done    (frame_done),
        .proto_err     (proto_err),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Pulse and handshake monitor
    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            done_rv  <= res_valid;
            done_rd  <= res_data;
        end
        if (proto_err) perr_cnt <= perr_cnt + 1;
        if (res_valid && res_ready) begin
            got_data.push_back(res_data);
            got_idx.push_back(res_idx);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        t = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            t = b[i];
            repeat (CPB) @(negedge clk);
        end
        t = stop;
        repeat (CPB) @(negedge clk);
        t = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        nchk++; if (res_valid !== 1'b0) begin nfail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        nchk++; if (res_data !== 10'd0) begin nfail++; $display("FAIL reset_res_data: got %h want 000", res_data); end
        nchk++; if (res_idx !== 6'd0) begin nfail++; $display("FAIL reset_res_idx: got %0d want 0", res_idx); end
        nchk++; if ({frame_cap, frame_err_code, frame_count} !== 12'd0) begin nfail++; $display("FAIL reset_frame_fields: got cap %0d err %0d cnt %0d want 0", frame_cap, frame_err_code, frame_count); end
        nchk++; if ({frame_done, proto_err, overrun} !== 3'b000) begin nfail++; $display("FAIL reset_flags: got %b want 000", {frame_done, proto_err, overrun}); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_good_frame();
        int d0 = done_cnt;
        int p0 = perr_cnt;
        int g0 = got_data.size();
        send_byte(8'h85, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h03, 1'b1);
        nchk++; if (got_data.size() - g0 !== 2) begin nfail++; $display("FAIL good_nresults: got %0d want 2", got_data.size() - g0); end
        else begin
            nchk++; if (got_data[g0] !== 10'h134 || got_idx[g0] !== 6'd0) begin nfail++; $display("FAIL good_res0: got %h idx %0d want 134 idx 0", got_data[g0], got_idx[g0]); end
            nchk++; if (got_data[g0+1] !== 10'h3FF || got_idx[g0+1] !== 6'd1) begin nfail++; $display("FAIL good_res1: got %h idx %0d want 3ff idx 1", got_data[g0+1], got_idx[g0+1]); end
        end
        nchk++; if (frame_cap !== 3'd5) begin nfail++; $display("FAIL good_cap: got %0d want 5", frame_cap); end
        nchk++; if (frame_count !== 6'd2) begin nfail++; $display("FAIL good_count: got %0d want 2", frame_count); end
        nchk++; if (frame_err_code !== 3'd0) begin nfail++; $display("FAIL good_err: got %0d want 0", frame_err_code); end
        nchk++; if (done_cnt - d0 !== 1) begin nfail++; $display("FAIL good_done: got %0d pulses want 1", done_cnt - d0); end
        nchk++; if (perr_cnt - p0 !== 0) begin nfail++; $display("FAIL good_perr: got %0d pulses want 0", perr_cnt - p0); end
        nchk++; if (done_rv !== 1'b1 || done_rd !== 10'h3FF) begin nfail++; $display("FAIL good_done_align: got valid %b data %h want 1 3ff", done_rv, done_rd); end
    endtask

    task automatic test_err_header();
        int d0 = done_cnt;
        int g0 = got_data.size();
        send_byte(8'h9B, 1'b1);
        nchk++; if (frame_err_code !== 3'd3) begin nfail++; $display("FAIL errhdr_err: got %0d want 3", frame_err_code); end
        nchk++; if (frame_cap !== 3'd3) begin nfail++; $display("FAIL errhdr_cap: got %0d want 3", frame_cap); end
        nchk++; if (frame_count !== 6'd0) begin nfail++; $display("FAIL errhdr_count: got %0d want 0", frame_count); end
        nchk++; if (done_cnt - d0 !== 1) begin nfail++; $display("FAIL errhdr_done: got %0d pulses want 1", done_cnt - d0); end
        nchk++; if (got_data.size() - g0 !== 0) begin nfail++; $display("FAIL errhdr_results: got %0d want 0", got_data.size() - g0); end
    endtask

    task automatic test_count_overflow();
        int d0 = done_cnt;
        int p0 = perr_cnt;
        send_byte(8'h85, 1'b1);
        send_byte(8'h11, 1'b1);
        nchk++; if (perr_cnt - p0 !== 1) begin nfail++; $display("FAIL ovf_perr: got %0d pulses want 1", perr_cnt - p0); end
        nchk++; if (done_cnt - d0 !== 0) begin nfail++; $display("FAIL ovf_nodone: got %0d pulses want 0", done_cnt - d0); end
        send_byte(8'h80, 1'b1);
        send_byte(8'h00, 1'b1);
        nchk++; if (done_cnt - d0 !== 1) begin nfail++; $display("FAIL zero_done: got %0d pulses want 1", done_cnt - d0); end
        nchk++; if (frame_count !== 6'd0 || frame_cap !== 3'd0 || frame_err_code !== 3'd0) begin nfail++; $display("FAIL zero_fields: got cnt %0d cap %0d err %0d want 0 0 0", frame_count, frame_cap, frame_err_code); end
    endtask

    task automatic test_stop_error();
        int d0 = done_cnt;
        int p0 = perr_cnt;
        int g0 = got_data.size();
        send_byte(8'h80, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h00, 1'b1);
        nchk++; if (perr_cnt - p0 !== 1) begin nfail++; $display("FAIL stop_perr: got %0d pulses want 1", perr_cnt - p0); end
        nchk++; if (done_cnt - d0 !== 0 || got_data.size() - g0 !== 0) begin nfail++; $display("FAIL stop_discard: got done %0d results %0d want 0 0", done_cnt - d0, got_data.size() - g0); end
        send_byte(8'h80, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h02, 1'b1);
        nchk++; if (got_data.size() - g0 !== 1) begin nfail++; $display("FAIL stop_recover_n: got %0d want 1", got_data.size() - g0); end
        else begin
            nchk++; if (got_data[g0] !== 10'h255) begin nfail++; $display("FAIL stop_recover_data: got %h want 255", got_data[g0]); end
        end
        nchk++; if (done_cnt - d0 !== 1 || frame_count !== 6'd1) begin nfail++; $display("FAIL stop_recover_done: got done %0d cnt %0d want 1 1", done_cnt - d0, frame_count); end
    endtask

    task automatic test_glitch();
        int p0 = perr_cnt;
        int g0 = got_data.size();
        send_byte(8'h80, 1'b1);
        // Under half a bit low while idle: if taken as a start bit it would yield 0xFF in CNT.
        t = 1'b0;
        repeat (CPB / 2 - 1) @(negedge clk);
        t = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        nchk++; if (perr_cnt - p0 !== 0) begin nfail++; $display("FAIL glitch_perr: got %0d pulses want 0", perr_cnt - p0); end
        send_byte(8'h01, 1'b1);
        send_byte(8'h07, 1'b1);
        send_byte(8'h00, 1'b1);
        nchk++; if (got_data.size() - g0 !== 1) begin nfail++; $display("FAIL glitch_frame_n: got %0d want 1", got_data.size() - g0); end
        else begin
            nchk++; if (got_data[g0] !== 10'h007) begin nfail++; $display("FAIL glitch_frame_data: got %h want 007", got_data[g0]); end
        end
    endtask

    task automatic test_timeout();
        int p0 = perr_cnt;
        int d0 = done_cnt;
        int waited = 0;
        send_byte(8'h80, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (250) @(negedge clk);
        nchk++; if (perr_cnt - p0 !== 0) begin nfail++; $display("FAIL timeout_early: got %0d pulses want 0", perr_cnt - p0); end
        while (perr_cnt == p0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        nchk++; if (perr_cnt - p0 !== 1) begin nfail++; $display("FAIL timeout_perr: got %0d pulses want 1", perr_cnt - p0); end
        nchk++; if (done_cnt - d0 !== 0 || res_valid !== 1'b0) begin nfail++; $display("FAIL timeout_quiet: got done %0d valid %b want 0 0", done_cnt - d0, res_valid); end
    endtask

    task automatic test_overrun();
        int d0 = done_cnt;
        res_ready = 1'b0;
        send_byte(8'h80, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        nchk++; if (overrun !== 1'b0) begin nfail++; $display("FAIL ovr_not_yet: got %b want 0", overrun); end
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        nchk++; if (res_valid !== 1'b1 || res_data !== 10'h001 || res_idx !== 6'd0) begin nfail++; $display("FAIL ovr_held: got valid %b data %h idx %0d want 1 001 0", res_valid, res_data, res_idx); end
        nchk++; if (overrun !== 1'b1) begin nfail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        nchk++; if (done_cnt - d0 !== 1 || frame_count !== 6'd2) begin nfail++; $display("FAIL ovr_done: got done %0d cnt %0d want 1 2", done_cnt - d0, frame_count); end
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        nchk++; if (res_valid !== 1'b0 || overrun !== 1'b1) begin nfail++; $display("FAIL ovr_drain: got valid %b overrun %b want 0 1", res_valid, overrun); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_err_header();
        test_count_overflow();
        test_stop_error();
        test_glitch();
        test_timeout();
        test_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
